bcd_counter_n: RTL
==================

BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 SHALL provide parameter: DIGITS, 2, number of cascaded BCD decades (legal range 1..8).
REQ-002 SHALL provide port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 SHALL provide port: en  input  1  count enable, active-high.
REQ-005 SHALL provide port: up  input  1  direction, 1 = increment, 0 = decrement (see REQ-024/025).
REQ-006 SHALL provide port: load  input  1  synchronous parallel load strobe, active-high.
REQ-007 SHALL provide port: load_val  input  4*DIGITS  parallel load value, one BCD digit per nibble.
REQ-008 SHALL provide port: count  output  4*DIGITS  registered count; digit i occupies bits [4i+3:4i], digit 0 least significant.
REQ-009 SHALL provide port: tc  output  1  combinational terminal count for cascading.
REQ-010 SHALL provide port: wrap  output  1  registered one-cycle pulse on full-range wrap.

Function
REQ-011 Update priority on each rising clk SHALL be rst > load > en; with none active, count and all state SHALL hold.
REQ-012 load SHALL write load_val into count in one cycle, regardless of en and up.
REQ-013 On load, any nibble of load_val in 10..15 SHALL be written as 0 for that digit; legal nibbles SHALL be written unchanged.
REQ-014 With en=1 and counting up, digit 0 SHALL increment every cycle; digit i>0 SHALL increment only when all lower digits equal 9.
REQ-015 With counting up, a digit at 9 that increments SHALL become 0 (decade wrap).
REQ-016 With en=1 and counting down, digit 0 SHALL decrement every cycle; digit i>0 SHALL decrement only when all lower digits equal 0.
REQ-017 With counting down, a digit at 0 that decrements SHALL become 9.
REQ-018 Every digit of count SHALL remain in 0..9 at all times after the first reset.
REQ-019 tc SHALL equal en AND NOT load AND (all digits 9 when counting up, or all digits 0 when counting down); tc SHALL be 0 otherwise.
REQ-020 wrap SHALL be 1 in the cycle after a clock edge at which tc was 1, and 0 in every other cycle.
REQ-021 Full-range wrap SHALL occur with no skipped or repeated value: up from all-9s gives all-0s; down from all-0s gives all-9s.
REQ-022 Latency: count SHALL reflect load or enabled step exactly one clock after the qualifying edge.

Reset
REQ-023 rst=1 at a rising edge SHALL set count to 0 and wrap to 0, overriding load and en in the same cycle, including mid-count and mid-load.

Configuration
REQ-024 With macro BCD_COUNTER_DOWN_EN defined, direction SHALL follow the up input per REQ-014..REQ-019.
REQ-025 Without BCD_COUNTER_DOWN_EN, the up input SHALL be ignored, counting SHALL always be upward, and tc SHALL decode only all-9s.

Verification (DIGITS=2, BCD_COUNTER_DOWN_EN defined unless noted)
REQ-026 rst=1 one cycle from arbitrary state, then en=1 up=1 for 100 cycles -> count steps 00,01..09,10..99,00; wrap high exactly once, in the cycle count=00 after 99.
REQ-027 load=1 load_val=0x39 -> count=39 next cycle; then en=1 up=1 -> 40; with up=0 from 40 -> 39.
REQ-028 load_val=0xAF with load=1 -> count=00; load_val=0x5C -> count=50.
REQ-029 count=00, en=1 up=0 -> tc=1 this cycle, count=99 and wrap=1 next cycle; count=99 with en=0 -> tc=0, count holds.
REQ-030 rst=1, load=1 and en=1 in the same cycle at count=57 -> count=00, wrap=0 next cycle.
REQ-031 Without BCD_COUNTER_DOWN_EN: count=05, en=1 up=0 for 3 cycles -> 06,07,08; tc=0 at count=00.

Source files
------------

// File: rtl/bcd_counter_n.sv
// ---------------------------------------------------------------------------
// bcd_counter_n
//   Parameterised chain of DIGITS cascaded BCD decades with synchronous
//   parallel load. The counter can step up or down and flags terminal count
//   and full-range wrap.
//
//   Optional feature macro: BCD_COUNTER_DOWN_EN
//     defined   -> 'up' selects the direction (1 = increment, 0 = decrement)
//     undefined -> 'up' is ignored, the counter always increments, and tc
//                  decodes only the all-9s state
//
//   Ports
//     clk      in   sole clock, all state updates on rising edge
//     rst      in   synchronous active-high reset (count = 0, wrap = 0)
//     en       in   count enable
//     up       in   direction (only used with BCD_COUNTER_DOWN_EN)
//     load     in   synchronous parallel load strobe (priority over en)
//     load_val in   load value, one BCD digit per nibble; nibbles 10..15
//                   are loaded as 0
//     count    out  registered count, digit 0 in bits [3:0]
//     tc       out  combinational terminal count for cascading
//     wrap     out  registered one-cycle pulse following a full-range wrap
// ---------------------------------------------------------------------------
module bcd_counter_n #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  wrap
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                wrap_q, wrap_d;

    logic                dir_up;
    logic [4*DIGITS-1:0] step_val;
    logic [4*DIGITS-1:0] load_clean;
    logic                at_end;

`ifdef BCD_COUNTER_DOWN_EN
    assign dir_up = up;
`else
    logic unused_up;
    assign unused_up = up;
    assign dir_up    = 1'b1;
`endif

    // Ripple carry/borrow across decades: a digit steps only while every
    // lower digit sits at its extreme (9 going up, 0 going down). The carry
    // surviving past the top digit therefore means "all digits at extreme".
    always_comb begin
        logic       carry;
        logic [3:0] dig;
        step_val = count_q;
        carry    = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (carry) begin
                if (dir_up) begin
                    step_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                end else begin
                    step_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                end
            end
            carry = carry & (dir_up ? (dig == 4'd9) : (dig == 4'd0));
        end
        at_end = carry;
    end

    // Illegal load nibbles are forced to 0 so count never leaves BCD range.
    always_comb begin
        logic [3:0] ld_dig;
        load_clean = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            ld_dig = load_val[4*i +: 4];
            load_clean[4*i +: 4] = (ld_dig > 4'd9) ? 4'd0 : ld_dig;
        end
    end

    assign tc = en & ~load & at_end;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_clean;
        end else if (en) begin
            count_d = step_val;
        end
        wrap_d = tc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule
